// File: rtl/shift_seq32.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR). It shifts one bit position per clock and returns
// the result with a start/busy/done handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; operands are latched on accept
// S_SHIFT | one bit shift per clock, r_cnt counts down to zero
// S_DONE  | publish work register to res/zero, pulse done
module shift_seq32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_done;

  logic [WIDTH-1:0] w_shifted;
  logic [SHW-1:0]   w_amt;
  logic             w_unused_a_hi;

  // Amount is taken modulo WIDTH; the upper operand bits are deliberately dropped.
  assign w_amt         = A[SHW-1:0];
  assign w_unused_a_hi = ^A[WIDTH-1:SHW];

  always_comb begin
    w_shifted = r_work;
    case (r_op)
      OP_SLL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = {r_work[0], r_work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= B;
            r_cnt   <= w_amt;
            r_op    <= op;
            r_state <= (w_amt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - 1'b1;
          // The last shift happens on the edge where the count reaches zero.
          if (r_cnt == SHW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_res   <= r_work;
          r_zero  <= (r_work == '0);
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign res  = r_res;
  assign zero = r_zero;
  assign done = r_done;

endmodule
